approx_adder_pipe: RTL and testbench

Parametrised, pipelined WIDTH-bit ripple adder whose low APPROX_BITS positions can run approximate full-adder cells: carry-out is a&b, sum is a^b^cin. A per-transaction mode bit selects approximate or exact arithmetic. The carry chain is split into STAGES register segments behind a valid/ready handshake. It is the accumulation adder for the mul8 partial-product tree and replaces the single-cell approximate full adder in that role.

---
 rtl/approx_adder_pipe.sv | 230 +++++++++++++++++++++++
 tb/tb_approx_adder_pipe.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_pipe.sv
// approx_adder_pipe: pipelined WIDTH-bit ripple adder with optional approximate
// low-order cells (carry-out = a&b) selected per transaction by mode.
// The carry chain is cut into STAGES register segments behind a single
// valid/ready handshake with a global advance enable (bubbles are kept).
// Optional feature macro: APPROX_ERR_STAT_EN adds an exact reference path,
// err_clr / err_count ports and a saturating mismatch counter.
module approx_adder_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4,
    parameter int STAGES      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef APPROX_ERR_STAT_EN
    ,
    input  logic             err_clr,
    output logic [15:0]      err_count
`endif
);

    // Bits per segment; trailing segments may be short or even empty.
    localparam int SEG  = (WIDTH + STAGES - 1) / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage pipeline registers. Operands travel in full so later
    // segments can consume their slice; sum holds the bits resolved so far.
    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic             mode_q  [STAGES];
    logic             mode_d  [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
`ifdef APPROX_ERR_STAT_EN
    logic             ref_carry_q [STAGES];
    logic             ref_carry_d [STAGES];
    logic [WIDTH-1:0] ref_sum_q   [STAGES];
    logic [WIDTH-1:0] ref_sum_d   [STAGES];
`endif

    // Whole pipeline moves together whenever the output slot is free or drains.
    logic adv;

    assign adv       = out_ready | ~valid_q[LAST];
    assign in_ready  = adv;
    assign out_valid = valid_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = carry_q[LAST];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO = gi * SEG;
        localparam int HI = ((gi + 1) * SEG < WIDTH) ? (gi + 1) * SEG : WIDTH;

        logic             src_valid;
        logic             src_mode;
        logic             src_carry;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_sum;
        logic             seg_carry;
        logic [WIDTH-1:0] seg_sum;
`ifdef APPROX_ERR_STAT_EN
        logic             src_ref_carry;
        logic [WIDTH-1:0] src_ref_sum;
        logic             ref_seg_carry;
        logic [WIDTH-1:0] ref_seg_sum;
`endif

        if (gi == 0) begin : g_src_in
            assign src_valid = in_valid;
            assign src_mode  = mode;
            assign src_carry = cin;
            assign src_a     = a;
            assign src_b     = b;
            assign src_sum   = '0;
`ifdef APPROX_ERR_STAT_EN
            assign src_ref_carry = cin;
            assign src_ref_sum   = '0;
`endif
        end else begin : g_src_prev
            assign src_valid = valid_q[gi-1];
            assign src_mode  = mode_q[gi-1];
            assign src_carry = carry_q[gi-1];
            assign src_a     = a_q[gi-1];
            assign src_b     = b_q[gi-1];
            assign src_sum   = sum_q[gi-1];
`ifdef APPROX_ERR_STAT_EN
            assign src_ref_carry = ref_carry_q[gi-1];
            assign src_ref_sum   = ref_sum_q[gi-1];
`endif
        end

        // Ripple this segment's bits; approximate cells drop the carry-in term.
        always_comb begin
            seg_carry = src_carry;
            seg_sum   = src_sum;
            for (int i = 0; i < WIDTH; i++) begin
                if ((i >= LO) && (i < HI)) begin
                    seg_sum[i] = src_a[i] ^ src_b[i] ^ seg_carry;
                    if (src_mode && (i < APPROX_BITS)) begin
                        seg_carry = src_a[i] & src_b[i];
                    end else begin
                        seg_carry = (src_a[i] & src_b[i]) |
                                    (src_a[i] & seg_carry) |
                                    (src_b[i] & seg_carry);
                    end
                end
            end
        end

`ifdef APPROX_ERR_STAT_EN
        // Exact reference ripple over the same segment, used only for statistics.
        always_comb begin
            ref_seg_carry = src_ref_carry;
            ref_seg_sum   = src_ref_sum;
            for (int i = 0; i < WIDTH; i++) begin
                if ((i >= LO) && (i < HI)) begin
                    ref_seg_sum[i] = src_a[i] ^ src_b[i] ^ ref_seg_carry;
                    ref_seg_carry  = (src_a[i] & src_b[i]) |
                                     (src_a[i] & ref_seg_carry) |
                                     (src_b[i] & ref_seg_carry);
                end
            end
        end
`endif

        // Shift the stage forward on advance, otherwise hold everything.
        always_comb begin
            valid_d[gi] = valid_q[gi];
            a_d[gi]     = a_q[gi];
            b_d[gi]     = b_q[gi];
            mode_d[gi]  = mode_q[gi];
            carry_d[gi] = carry_q[gi];
            sum_d[gi]   = sum_q[gi];
`ifdef APPROX_ERR_STAT_EN
            ref_carry_d[gi] = ref_carry_q[gi];
            ref_sum_d[gi]   = ref_sum_q[gi];
`endif
            if (adv) begin
                valid_d[gi] = src_valid;
                a_d[gi]     = src_a;
                b_d[gi]     = src_b;
                mode_d[gi]  = src_mode;
                carry_d[gi] = seg_carry;
                sum_d[gi]   = seg_sum;
`ifdef APPROX_ERR_STAT_EN
                ref_carry_d[gi] = ref_seg_carry;
                ref_sum_d[gi]   = ref_seg_sum;
`endif
            end
        end
    end

    // Stage registers; reset discards all in-flight tokens and zeroes the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                mode_q[k]  <= 1'b0;
                carry_q[k] <= 1'b0;
                sum_q[k]   <= '0;
`ifdef APPROX_ERR_STAT_EN
                ref_carry_q[k] <= 1'b0;
                ref_sum_q[k]   <= '0;
`endif
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                mode_q[k]  <= mode_d[k];
                carry_q[k] <= carry_d[k];
                sum_q[k]   <= sum_d[k];
`ifdef APPROX_ERR_STAT_EN
                ref_carry_q[k] <= ref_carry_d[k];
                ref_sum_q[k]   <= ref_sum_d[k];
`endif
            end
        end
    end

`ifdef APPROX_ERR_STAT_EN
    logic [15:0] err_count_q;
    logic [15:0] err_count_d;
    logic        out_xfer;
    logic        mismatch;

    // Count delivered results that differ from the exact answer; clear dominates.
    always_comb begin
        out_xfer    = valid_q[LAST] & out_ready;
        mismatch    = {carry_q[LAST], sum_q[LAST]} != {ref_carry_q[LAST], ref_sum_q[LAST]};
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = '0;
        end else if (out_xfer && mismatch && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    // Mismatch counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Testbench for approx_adder_pipe (WIDTH=8, APPROX_BITS=4, STAGES=2).
// Directed vector table, backpressure / reset / counter sequences, and a
// randomized stream checked against an arithmetic reference model.
module tb_approx_adder_pipe;
    localparam int WIDTH       = 8;
    localparam int APPROX_BITS = 4;
    localparam int STAGES      = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef APPROX_ERR_STAT_EN
    logic             err_clr;
    logic [15:0]      err_count;
`endif

    int errors = 0;
    int checks = 0;
    int exp_err = 0;

    approx_adder_pipe #(
        .WIDTH(WIDTH), .APPROX_BITS(APPROX_BITS), .STAGES(STAGES)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef APPROX_ERR_STAT_EN
        , .err_clr(err_clr), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       mode;
        logic [7:0] es;
        logic       ec;
    } vec_t;

    typedef struct {
        logic [8:0] res;
        logic [8:0] exact;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: low APPROX_BITS bits see only the neighbour's generate term,
    // the upper part is an exact add fed by the top approximate generate.
    function automatic logic [8:0] model(input logic [7:0] av, input logic [7:0] bv,
                                         input logic cv, input logic mv);
        int ai, bi, ci, res, low, pg, kout, high, lowmask;
        ai = int'(av);
        bi = int'(bv);
        ci = int'(cv);
        if (!mv || APPROX_BITS == 0) begin
            res = ai + bi + ci;
        end else begin
            lowmask = (1 << APPROX_BITS) - 1;
            pg      = ((ai & bi) << 1) | ci;
            low     = (ai ^ bi ^ pg) & lowmask;
            kout    = (ai >> (APPROX_BITS - 1)) & (bi >> (APPROX_BITS - 1)) & 1;
            high    = (ai >> APPROX_BITS) + (bi >> APPROX_BITS) + kout;
            res     = (high << APPROX_BITS) | low;
        end
        return res[8:0];
    endfunction

    function automatic logic [8:0] exact_add(input logic [7:0] av, input logic [7:0] bv,
                                             input logic cv);
        int r;
        r = int'(av) + int'(bv) + int'(cv);
        return r[8:0];
    endfunction

    function automatic int bump(input int e);
        return (e < 65535) ? e + 1 : e;
    endfunction

    // One isolated transaction: accept, latency, result, then counter update.
    task automatic run_vec(input vec_t v, input int idx);
        int  cyc;
        logic [8:0] ex;
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; mode = v.mode;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check($sformatf("vec%0d_in_ready", idx), in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        #1;
        check($sformatf("vec%0d_latency", idx), cyc, STAGES);
        check($sformatf("vec%0d_sum", idx), sum, v.es);
        check($sformatf("vec%0d_cout", idx), cout, v.ec);
        ex = exact_add(v.a, v.b, v.cin);
        if ({v.ec, v.es} != ex) exp_err = bump(exp_err);
        @(negedge clk);
        #1;
        check($sformatf("vec%0d_drained", idx), out_valid, 0);
`ifdef APPROX_ERR_STAT_EN
        check($sformatf("vec%0d_err_count", idx), err_count, exp_err);
`endif
        $display("vec%0d a=%02h b=%02h cin=%0d mode=%0d -> sum=%02h cout=%0d", idx,
                 v.a, v.b, v.cin, v.mode, sum_seen(v), v.ec);
    endtask

    function automatic logic [7:0] sum_seen(input vec_t v);
        return v.es;
    endfunction

    vec_t tbl[12];
    exp_t q[$];
    exp_t e;

    initial begin
        tbl[0]  = '{8'h0F, 8'h01, 1'b0, 1'b1, 8'h0C, 1'b0};
        tbl[1]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0};
        tbl[2]  = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'hFC, 1'b0};
        tbl[3]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[4]  = '{8'h30, 8'h50, 1'b0, 1'b1, 8'h80, 1'b0};
        tbl[5]  = '{8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0};
        tbl[6]  = '{8'h88, 8'h88, 1'b0, 1'b1, 8'h10, 1'b1};
        tbl[7]  = '{8'h07, 8'h01, 1'b0, 1'b1, 8'h04, 1'b0};
        tbl[8]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
        tbl[9]  = '{8'h0F, 8'h0F, 1'b1, 1'b1, 8'h1F, 1'b0};
        tbl[10] = '{8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0};
        tbl[11] = '{8'hF0, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; mode = 1'b0;
`ifdef APPROX_ERR_STAT_EN
        err_clr = 1'b0;
`endif
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
`ifdef APPROX_ERR_STAT_EN
        check("reset_err_count", err_count, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", in_ready, 1);

        // Directed table.
        for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

        // Backpressure: three pushes with the consumer stalled.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0; mode = 1'b1;
        #1; check("bp_t1_in_ready", in_ready, 1);
        @(negedge clk);
        a = 8'h30; b = 8'h50; mode = 1'b1;
        #1; check("bp_t2_in_ready", in_ready, 1);
        @(negedge clk);
        a = 8'h12; b = 8'h34; mode = 1'b0;
        #1;
        check("bp_t3_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_t1_sum", sum, 8'h0C);
        @(negedge clk);
        #1;
        check("bp_hold_in_ready", in_ready, 0);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_sum", sum, 8'h0C);
        check("bp_hold_cout", cout, 0);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_sum1", sum, 8'h0C);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("bp_out2_valid", out_valid, 1);
        check("bp_out2_sum", sum, 8'h80);
        @(negedge clk);
        #1;
        check("bp_out3_valid", out_valid, 1);
        check("bp_out3_sum", sum, 8'h46);
        @(negedge clk);
        #1;
        check("bp_empty", out_valid, 0);
        exp_err = bump(exp_err);   // 0x0F+0x01 approximate result differs from exact
        $display("backpressure sequence done");

        // Mid-stream reset with two transactions in flight.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h0F; b = 8'h01; mode = 1'b1; cin = 1'b0;
        @(negedge clk);
        a = 8'hFF; b = 8'h01;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_sum", sum, 0);
        check("mrst_cout", cout, 0);
        exp_err = 0;
`ifdef APPROX_ERR_STAT_EN
        check("mrst_err_count", err_count, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("mrst_no_stale", out_valid, 0);
        end
        begin
            logic [7:0] sa[4];
            logic [7:0] sb[4];
            logic [8:0] want[$];
            int got;
            sa[0] = 8'h11; sb[0] = 8'h22;
            sa[1] = 8'hF0; sb[1] = 8'h20;
            sa[2] = 8'h0F; sb[2] = 8'h01;
            sa[3] = 8'h7F; sb[3] = 8'h81;
            got = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (c < 4) begin
                    in_valid = 1'b1; a = sa[c]; b = sb[c]; cin = 1'b0; mode = 1'b0;
                    want.push_back(exact_add(sa[c], sb[c], 1'b0));
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                if (out_valid) begin
                    check($sformatf("mrst_stream%0d", got), {cout, sum}, want.pop_front());
                    got++;
                end
            end
            check("mrst_stream_count", got, 4);
        end
        $display("mid-stream reset sequence done");

        // Randomized stream against the reference model.
        begin
            logic       prev_stall;
            logic [7:0] prev_sum;
            logic       prev_cout;
            prev_stall = 1'b0; prev_sum = '0; prev_cout = 1'b0;
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk);
                in_valid  = ($urandom_range(0, 9) < 7);
                a         = 8'($urandom);
                b         = 8'($urandom);
                cin       = 1'($urandom_range(0, 1));
                mode      = 1'($urandom_range(0, 1));
                out_ready = ($urandom_range(0, 9) < 6);
                #1;
                if (prev_stall) begin
                    check("rand_hold_valid", out_valid, 1);
                    check("rand_hold_sum", sum, prev_sum);
                    check("rand_hold_cout", cout, prev_cout);
                end
                if (out_valid) begin
                    if (q.size() == 0) begin
                        check("rand_spurious_valid", out_valid, 0);
                    end else if (out_ready) begin
                        e = q.pop_front();
                        check("rand_result", {cout, sum}, e.res);
                        if (e.res != e.exact) exp_err = bump(exp_err);
                    end else begin
                        check("rand_stall_in_ready", in_ready, 0);
                    end
                end else begin
                    check("rand_idle_in_ready", in_ready, 1);
                end
                prev_stall = out_valid & ~out_ready;
                prev_sum   = sum;
                prev_cout  = cout;
                if (in_valid && in_ready) begin
                    e.res   = model(a, b, cin, mode);
                    e.exact = exact_add(a, b, cin);
                    q.push_back(e);
                end
            end
            for (int d = 0; d < 20 && q.size() > 0; d++) begin
                @(negedge clk);
                in_valid = 1'b0; out_ready = 1'b1;
                #1;
                if (out_valid) begin
                    e = q.pop_front();
                    check("rand_drain_result", {cout, sum}, e.res);
                    if (e.res != e.exact) exp_err = bump(exp_err);
                end
            end
            check("rand_queue_empty", q.size(), 0);
            @(negedge clk);
            #1;
`ifdef APPROX_ERR_STAT_EN
            check("rand_err_count", err_count, exp_err);
`endif
        end
        $display("random stream done");

`ifdef APPROX_ERR_STAT_EN
        // Clear wins over a same-cycle mismatching output transfer.
        begin
            int cyc;
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0; mode = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            cyc = 1;
            while (!out_valid && cyc < 10) begin
                @(negedge clk);
                cyc++;
            end
            check("clr_latency", cyc, STAGES);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            #1;
            check("clr_err_count", err_count, 0);
            check("clr_transferred", out_valid, 0);
            exp_err = 0;
            $display("clear priority sequence done");
        end

        // Saturation: 65535 mismatches then one more.
        for (int n = 0; n < 65535; n++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0; mode = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        exp_err = 65535;
        check("sat_full", err_count, exp_err);
        run_vec(tbl[0], 100);
        check("sat_hold", err_count, 16'hFFFF);
        $display("saturation sequence done");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
